// File: rtl/fetch_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_seq_ctrl_pkg
// Description : Shared state encodings and reset constants for the fetch
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_seq_ctrl_pkg;

    localparam logic [0:0]  S_FETCH    = 1'b0;
    localparam logic [0:0]  S_HOLD     = 1'b1;

    localparam logic [31:0] c_reset_pc = 32'h0000_3000;
    localparam logic [31:0] c_nop_word = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_seq_ctrl_tgt_latch.sv
`default_nettype none
// ============================================================================
// Module      : fetch_tgt_latch
// Description : Holds the D-stage redirect target and annul flag across fetch
//               wait states so a delay slot still lands on the right target.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_tgt_latch (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_capture,
    input  logic        i_clear,
    input  logic [31:0] i_npc,
    input  logic        i_annul,
    output logic [31:0] o_tgt,
    output logic        o_tgt_vld,
    output logic        o_annul
);

    logic [31:0] r_tgt;
    logic        r_tgt_vld;
    logic        r_annul;

    // First capture wins: later wait cycles see a bubble in D, not the branch.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tgt     <= '0;
            r_tgt_vld <= 1'b0;
            r_annul   <= 1'b0;
        end else if (i_clear) begin
            r_tgt_vld <= 1'b0;
            r_annul   <= 1'b0;
        end else if (i_capture && !r_tgt_vld) begin
            r_tgt     <= i_npc;
            r_annul   <= i_annul;
            r_tgt_vld <= 1'b1;
        end
    end

    assign o_tgt     = r_tgt;
    assign o_tgt_vld = r_tgt_vld;
    assign o_annul   = r_annul;

endmodule
`default_nettype wire

// File: rtl/fetch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_seq_ctrl
// Description : Fetch sequencer owning the PC, the instruction-memory request
//               handshake and the F/D enable/nop controls. Define
//               FETCH_PERF_EN to add saturating performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_seq_ctrl
    import fetch_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc,
    parameter logic [31:0] NOP_WORD = c_nop_word
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_i,
    input  logic [31:0] npc_i,
    input  logic        annul_i,
    output logic        im_req_o,
    output logic [31:0] im_addr_o,
    input  logic        im_ready_i,
    input  logic [31:0] im_rdata_i,
    output logic [31:0] F_pc_o,
    output logic [31:0] F_instr_o,
    output logic        fd_en_o,
    output logic        fd_nop_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_o,
    output logic [31:0] perf_bubble_o,
    output logic [31:0] perf_annul_o
`endif
);

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_buf;

    logic        w_avail;
    logic        w_capture;
    logic        w_clear;
    logic [31:0] w_tgt;
    logic        w_tgt_vld;
    logic        w_tgt_annul;
    logic [31:0] w_next_pc;
    logic        w_kill;

    assign w_avail   = ((r_state == S_FETCH) && im_ready_i) || (r_state == S_HOLD);
    assign w_capture = reset_n && !stall_i && !w_avail;
    assign w_clear   = reset_n && !stall_i && w_avail;
    assign w_next_pc = w_tgt_vld ? w_tgt : npc_i;
    assign w_kill    = w_tgt_vld ? w_tgt_annul : annul_i;

    fetch_tgt_latch u_tgt_latch (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_capture (w_capture),
        .i_clear   (w_clear),
        .i_npc     (npc_i),
        .i_annul   (annul_i),
        .o_tgt     (w_tgt),
        .o_tgt_vld (w_tgt_vld),
        .o_annul   (w_tgt_annul)
    );

    // A word returned during a stall is parked in r_buf so it is never re-fetched.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_buf   <= NOP_WORD;
        end else if (stall_i) begin
            if ((r_state == S_FETCH) && im_ready_i) begin
                r_buf   <= im_rdata_i;
                r_state <= S_HOLD;
            end
        end else if (w_avail) begin
            r_pc    <= w_next_pc;
            r_state <= S_FETCH;
        end
    end

    always_comb begin
        im_req_o  = reset_n && (r_state == S_FETCH);
        F_pc_o    = reset_n ? r_pc : RESET_PC;
        im_addr_o = F_pc_o;
        F_instr_o = (r_state == S_HOLD) ? r_buf : im_rdata_i;
        fd_en_o   = !reset_n || !stall_i;
        fd_nop_o  = !reset_n || (!stall_i && (!w_avail || w_kill));
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_bubble;
    logic [31:0] r_perf_annul;
    logic        w_ev_bubble;
    logic        w_ev_annul;

    assign w_ev_bubble = !stall_i && !w_avail;
    assign w_ev_annul  = !stall_i && w_avail && w_kill;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_perf_stall  <= '0;
            r_perf_bubble <= '0;
            r_perf_annul  <= '0;
        end else begin
            if (stall_i && (r_perf_stall != 32'hFFFF_FFFF))
                r_perf_stall <= r_perf_stall + 32'd1;
            if (w_ev_bubble && (r_perf_bubble != 32'hFFFF_FFFF))
                r_perf_bubble <= r_perf_bubble + 32'd1;
            if (w_ev_annul && (r_perf_annul != 32'hFFFF_FFFF))
                r_perf_annul <= r_perf_annul + 32'd1;
        end
    end

    assign perf_stall_o  = r_perf_stall;
    assign perf_bubble_o = r_perf_bubble;
    assign perf_annul_o  = r_perf_annul;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_seq_ctrl
// Description : Scoreboard bench for fetch_seq_ctrl; expected F/D writes are
//               queued per cycle and retired whenever fd_en_o is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_seq_ctrl;

    localparam logic [31:0] c_nop   = 32'h0000_0000;
    localparam logic [31:0] c_xor   = 32'hC0DE_0000;

    typedef struct packed {
        logic        nop;
        logic [31:0] pc;
        logic [31:0] word;
    } sb_t;

    logic        clk;
    logic        reset_n;
    logic        stall_i;
    logic [31:0] npc_i;
    logic        annul_i;
    logic        im_req_o;
    logic [31:0] im_addr_o;
    logic        im_ready_i;
    logic [31:0] im_rdata_i;
    logic [31:0] F_pc_o;
    logic [31:0] F_instr_o;
    logic        fd_en_o;
    logic        fd_nop_o;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_o;
    logic [31:0] perf_bubble_o;
    logic [31:0] perf_annul_o;
`endif

    logic        br_ovr;
    logic [31:0] br_tgt;
    logic        garble;
    int          n_checks;
    int          n_errors;
    sb_t         sb[$];

    // D-stage model: fall-through unless a redirect is being forced.
    assign npc_i      = br_ovr ? br_tgt : F_pc_o + 32'd4;
    assign im_rdata_i = garble ? 32'hDEAD_BEEF : (im_addr_o ^ c_xor);

    fetch_seq_ctrl u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .stall_i    (stall_i),
        .npc_i      (npc_i),
        .annul_i    (annul_i),
        .im_req_o   (im_req_o),
        .im_addr_o  (im_addr_o),
        .im_ready_i (im_ready_i),
        .im_rdata_i (im_rdata_i),
        .F_pc_o     (F_pc_o),
        .F_instr_o  (F_instr_o),
        .fd_en_o    (fd_en_o),
        .fd_nop_o   (fd_nop_o)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_o  (perf_stall_o),
        .perf_bubble_o (perf_bubble_o),
        .perf_annul_o  (perf_annul_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // kind: 0 = stall (no write), 1 = bubble/nop, 2 = valid word at pc, 3 = reset
    task automatic drv(input logic rdy, input logic st, input logic an,
                       input int kind, input logic [31:0] pc);
        sb_t e;
        im_ready_i = rdy;
        stall_i    = st;
        annul_i    = an;
        if (kind == 1) begin
            e = '{nop: 1'b1, pc: 32'h0, word: c_nop};
            sb.push_back(e);
        end else if (kind == 2) begin
            e = '{nop: 1'b0, pc: pc, word: pc ^ c_xor};
            sb.push_back(e);
        end
        @(negedge clk);
        chk("fd_en", {31'd0, fd_en_o}, {31'd0, kind != 0});
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (reset_n === 1'b1 && fd_en_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("fd_nop", {31'd0, fd_nop_o}, {31'd0, e.nop});
                if (!e.nop) begin
                    chk("F_pc", F_pc_o, e.pc);
                    chk("F_instr", F_instr_o, e.word);
                end
            end
        end
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset_n    = 1'b0;
        stall_i    = 1'b0;
        annul_i    = 1'b0;
        im_ready_i = 1'b0;
        br_ovr     = 1'b0;
        br_tgt     = 32'h0;
        garble     = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        drv(1'b1, 1'b0, 1'b0, 3, 32'h0);
        chk("rst_req", {31'd0, im_req_o}, 32'd0);
        chk("rst_nop", {31'd0, fd_nop_o}, 32'd1);
        chk("rst_pc", F_pc_o, 32'h0000_3000);
        nxt();
        reset_n = 1'b1;

        // Wait states at 0x3004
        drv(1'b1, 1'b0, 1'b0, 2, 32'h3000); nxt();
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 1'b0, 1'b0, 1, 32'h0);
            chk("wait_addr", im_addr_o, 32'h3004);
            chk("wait_req", {31'd0, im_req_o}, 32'd1);
            nxt();
        end
        drv(1'b1, 1'b0, 1'b0, 2, 32'h3004);
        chk("wait_addr", im_addr_o, 32'h3004);
        nxt();
        for (int p = 32'h3008; p <= 32'h3014; p += 4) begin
            drv(1'b1, 1'b0, 1'b0, 2, p); nxt();
        end

        // Branch at 0x3014 to 0x3040, delay slot fetch waits 2 cycles
        br_ovr = 1'b1; br_tgt = 32'h3040;
        drv(1'b0, 1'b0, 1'b0, 1, 32'h0); nxt();
        br_tgt = 32'h300C;
        drv(1'b0, 1'b0, 1'b0, 1, 32'h0);
        chk("ds_addr", im_addr_o, 32'h3018);
        nxt();
        drv(1'b1, 1'b0, 1'b0, 2, 32'h3018); nxt();
        br_ovr = 1'b0;
        drv(1'b1, 1'b0, 1'b0, 2, 32'h3040); nxt();
        drv(1'b1, 1'b0, 1'b0, 2, 32'h3044); nxt();

        // Two-cycle stall, word returned in the first
        drv(1'b1, 1'b1, 1'b0, 0, 32'h0);
        chk("stall_nop", {31'd0, fd_nop_o}, 32'd0);
        nxt();
        drv(1'b0, 1'b1, 1'b0, 0, 32'h0);
        chk("hold_req", {31'd0, im_req_o}, 32'd0);
        nxt();
        garble = 1'b1;
        drv(1'b0, 1'b0, 1'b0, 2, 32'h3048); nxt();
        garble = 1'b0;
        drv(1'b1, 1'b0, 1'b0, 2, 32'h304C); nxt();

        // Not-taken likely branch at 0x3050 nullifies its delay slot
        drv(1'b1, 1'b0, 1'b0, 2, 32'h3050); nxt();
        drv(1'b1, 1'b0, 1'b1, 1, 32'h0); nxt();
        drv(1'b1, 1'b0, 1'b0, 2, 32'h3058); nxt();

        // PC wrap through 0xFFFF_FFFC
        drv(1'b1, 1'b0, 1'b0, 2, 32'h305C); nxt();
        br_ovr = 1'b1; br_tgt = 32'hFFFF_FFF8;
        drv(1'b1, 1'b0, 1'b0, 2, 32'h3060); nxt();
        br_ovr = 1'b0;
        drv(1'b1, 1'b0, 1'b0, 2, 32'hFFFF_FFF8); nxt();
        drv(1'b1, 1'b0, 1'b0, 2, 32'hFFFF_FFFC); nxt();
        drv(1'b1, 1'b0, 1'b0, 2, 32'h0000_0000); nxt();
        drv(1'b1, 1'b0, 1'b0, 2, 32'h0000_0004); nxt();

        // Reset during a wait with a captured redirect pending
        br_ovr = 1'b1; br_tgt = 32'h3100;
        drv(1'b0, 1'b0, 1'b0, 1, 32'h0);
`ifdef FETCH_PERF_EN
        chk("perf_stall", perf_stall_o, 32'd2);
        chk("perf_bubble", perf_bubble_o, 32'd5);
        chk("perf_annul", perf_annul_o, 32'd1);
`endif
        nxt();
        br_ovr  = 1'b0;
        reset_n = 1'b0;
        drv(1'b0, 1'b0, 1'b0, 3, 32'h0);
        chk("rst2_req", {31'd0, im_req_o}, 32'd0);
        chk("rst2_pc", F_pc_o, 32'h0000_3000);
        nxt();
        reset_n = 1'b1;
        drv(1'b1, 1'b0, 1'b0, 2, 32'h3000);
`ifdef FETCH_PERF_EN
        chk("perf_stall_rst", perf_stall_o, 32'd0);
        chk("perf_bubble_rst", perf_bubble_o, 32'd0);
        chk("perf_annul_rst", perf_annul_o, 32'd0);
`endif
        nxt();
        drv(1'b1, 1'b0, 1'b0, 2, 32'h3004); nxt();

        chk("sb_left", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
